// File: rtl/rgb_sinp.sv
// rgb_sinp: WS2812b-style single-wire serial decoder.
// Packs 24 pulses into a G-R-B word, flags stream resets, writes a FIFO.
module rgb_sinp #(
   parameter int BIT_THRESH  = 58,
   parameter int GLITCH_MIN  = 10,
   parameter int STR_RST     = 4800,
   parameter int COUNTER_MAX = 7800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sig_in,
   input  logic        in_wr_fifo_full,
   output logic        out_wr_fifo_en,
   output logic [31:0] out_wr_fifo_data,
   output logic        out_overflow,
   output logic        out_frame_err
);

   localparam int CW = $clog2(COUNTER_MAX + 1);
   localparam logic [CW-1:0] MAX_C  = CW'(COUNTER_MAX);
   localparam logic [CW-1:0] RST_C  = CW'(STR_RST);
   localparam logic [CW-1:0] BIT_C  = CW'(BIT_THRESH);
   localparam logic [CW-1:0] GMIN_C = CW'(GLITCH_MIN);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [31:0]   RST_WORD = 32'hC000_0000;

   typedef enum logic [1:0] {
      S_SYNC,
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   state_t        state_q, state_d;
   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          s3_q, s3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bcnt_q, bcnt_d;
   logic [23:0]   shreg_q, shreg_d;
   logic          en_q, en_d;
   logic [31:0]   data_q, data_d;
   logic          ovf_q, ovf_d;
   logic          ferr_q, ferr_d;

   logic          rise;
   logic          bit_val;
   logic [CW-1:0] cnt_inc;
   logic          emit;
   logic          err_set;
   logic [31:0]   word;

   // pulse classification, packing and FIFO write decision
   always_comb begin
      s1_d    = sig_in;
      s2_d    = s1_q;
      s3_d    = s2_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      emit    = 1'b0;
      err_set = 1'b0;
      word    = RST_WORD;
      rise    = s2_q & ~s3_q;
      bit_val = (cnt_q >= BIT_C);
      cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + ONE_C;
      unique case (state_q)
         S_SYNC: begin
            if (s2_q) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == RST_C) state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (rise) begin
               cnt_d   = ONE_C;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (s2_q) begin
               cnt_d = cnt_inc;
               if (cnt_inc >= RST_C) begin
                  err_set = 1'b1;
                  bcnt_d  = '0;
                  cnt_d   = '0;
                  state_d = S_SYNC;
               end
            end else if (cnt_q < GMIN_C) begin
               err_set = 1'b1;
               bcnt_d  = '0;
               cnt_d   = ONE_C;
               state_d = S_SYNC;
            end else begin
               shreg_d = {shreg_q[22:0], bit_val};
               cnt_d   = ONE_C;
               state_d = S_LOW;
               if (bcnt_q == 5'd23) begin
                  emit   = 1'b1;
                  word   = {2'b10, 6'b0, shreg_q[22:0], bit_val};
                  bcnt_d = '0;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
         end
         S_LOW: begin
            if (s2_q) begin
               cnt_d   = ONE_C;
               state_d = S_HIGH;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == RST_C) begin
                  emit    = 1'b1;
                  word    = RST_WORD;
                  err_set = (bcnt_q != 5'd0);
                  bcnt_d  = '0;
                  state_d = S_IDLE;
               end
            end
         end
      endcase
      en_d   = emit & ~in_wr_fifo_full;
      data_d = en_d ? word : data_q;
      ovf_d  = ovf_q | (emit & in_wr_fifo_full);
      ferr_d = ferr_q | err_set;
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SYNC;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
         en_q    <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         en_q    <= en_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
      end
   end

   assign out_wr_fifo_en   = en_q;
   assign out_wr_fifo_data = data_q;
   assign out_overflow     = ovf_q;
   assign out_frame_err    = ferr_q;

endmodule

// File: tb/tb_rgb_sinp.sv
// tb_rgb_sinp: directed bench for rgb_sinp.
// Expected FIFO words are queued as stimulus is driven.
module tb_rgb_sinp;

   logic        clk = 1'b0;
   logic        rst;
   logic        sig_in;
   logic        full;
   logic        en;
   logic [31:0] data;
   logic        ovf;
   logic        ferr;

   logic [31:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        en_prev = 1'b0;

   localparam logic [31:0] RW = 32'hC000_0000;

   rgb_sinp #(
      .BIT_THRESH (6),
      .GLITCH_MIN (2),
      .STR_RST    (40),
      .COUNTER_MAX(50)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sig_in          (sig_in),
      .in_wr_fifo_full (full),
      .out_wr_fifo_en  (en),
      .out_wr_fifo_data(data),
      .out_overflow    (ovf),
      .out_frame_err   (ferr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write must be expected, in order
   always @(negedge clk) begin
      if (en === 1'b1) begin
         chk("en_pulse", {31'b0, en_prev}, 32'd0);
         chk("wr_expected", {31'b0, en}, {31'b0, exp_q.size() != 0});
         if (exp_q.size() != 0) chk("wr_data", data, exp_q.pop_front());
      end
      en_prev = (en === 1'b1);
   end

   task automatic drive(input logic v, input int n);
      sig_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         if (w[23-i]) pulse(8, 4);
         else pulse(3, 9);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle(input string tag);
      repeat (5) @(negedge clk);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_flags(input string tag, input logic o, input logic f);
      chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, o});
      chk({tag, "_ferr"}, {31'b0, ferr}, {31'b0, f});
   endtask

   initial begin
      rst    = 1'b1;
      sig_in = 1'b0;
      full   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_en", {31'b0, en}, 32'd0);
      chk("rst_data", data, 32'd0);
      chk_flags("rst", 1'b0, 1'b0);
      rst = 1'b0;

      // 1: basic frame then stream reset
      drive(1'b0, 45);
      exp_q.push_back(32'h8012_3456);
      exp_q.push_back(RW);
      send_bits(24'h123456, 24);
      drive(1'b0, 45);
      settle("t1_drain");
      chk_flags("t1", 1'b0, 1'b0);

      // 2: threshold, glitch-min and long-gap boundaries
      exp_q.push_back(32'h8000_2000);
      exp_q.push_back(RW);
      for (int i = 0; i < 24; i++) begin
         int h;
         int l;
         h = (i == 4) ? 5 : (i == 10) ? 6 : (i == 20) ? 2 : 3;
         l = (i == 15) ? 39 : 9;
         pulse(h, l);
      end
      drive(1'b0, 45);
      settle("t2_drain");
      chk_flags("t2", 1'b0, 1'b0);

      // 3: 1-clock glitch mid-word, then recovery
      send_bits(24'hFFFFFF, 5);
      drive(1'b1, 1);
      drive(1'b0, 45);
      settle("t3_glitch_drain");
      chk_flags("t3_glitch", 1'b0, 1'b1);
      exp_q.push_back(32'h80AB_CDEF);
      exp_q.push_back(RW);
      send_bits(24'hABCDEF, 24);
      drive(1'b0, 45);
      settle("t3_drain");
      chk_flags("t3", 1'b0, 1'b1);

      // 4: partial word ended by stream reset
      do_reset();
      drive(1'b0, 45);
      exp_q.push_back(RW);
      send_bits(24'hFFC000, 10);
      drive(1'b0, 45);
      settle("t4_part_drain");
      chk_flags("t4_part", 1'b0, 1'b1);
      exp_q.push_back(32'h805A_5A5A);
      exp_q.push_back(RW);
      send_bits(24'h5A5A5A, 24);
      drive(1'b0, 45);
      settle("t4_drain");

      // 5: FIFO full at word completion
      do_reset();
      drive(1'b0, 45);
      exp_q.push_back(RW);
      send_bits(24'hF0F0F1, 23);
      full = 1'b1;
      drive(1'b1, 8);
      drive(1'b0, 6);
      full = 1'b0;
      drive(1'b0, 45);
      settle("t5_full_drain");
      chk_flags("t5_full", 1'b1, 1'b0);
      exp_q.push_back(32'h80C3_C3C3);
      exp_q.push_back(RW);
      send_bits(24'hC3C3C3, 24);
      drive(1'b0, 45);
      settle("t5_drain");
      chk_flags("t5", 1'b1, 1'b0);

      // 6: reset mid-word
      send_bits(24'h777777, 12);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t6_rst_en", {31'b0, en}, 32'd0);
         chk("t6_rst_data", data, 32'd0);
         chk_flags("t6_rst", 1'b0, 1'b0);
      end
      rst = 1'b0;
      drive(1'b0, 45);
      exp_q.push_back(32'h8024_6813);
      exp_q.push_back(RW);
      send_bits(24'h246813, 24);
      drive(1'b0, 45);
      settle("t6_drain");
      chk_flags("t6", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rgb_sinp.md
# rgb_sinp

Serial-input decoder for WS2812b-style single-wire RGB LED streams, forming the receive end of the serial path whose transmit end drives the LED strip. It samples the asynchronous input `sig_in`, classifies each pulse as a "0" or "1" bit by its high time, and packs 24 bits into a G-R-B word. It also detects stream-reset (long low) gaps. Each result is written as one 32-bit word to a write-side FIFO, in the same status/G/R/B word format that the RGBW serial output block reads.

## Interface
- `BIT_THRESH`, 58: high time in clocks at or above which a pulse decodes as "1" (96 MHz: T0H≈38, T1H≈77).
- `GLITCH_MIN`, 10: minimum valid high time in clocks; shorter pulses are framing errors.
- `STR_RST`, 4800: consecutive low clocks that constitute a stream reset (50 µs at 96 MHz).
- `COUNTER_MAX`, 7800: counter ceiling; counter width = $clog2(COUNTER_MAX+1); requires STR_RST < COUNTER_MAX.
- `clk`  in  1  clock, 96 MHz, synchronous with FIFO w_clk.
- `rst`  in  1  reset, synchronous, active-high.
- `sig_in`  in  1  asynchronous serial line.
- `in_wr_fifo_full`  in  1  FIFO write-full.
- `out_wr_fifo_en`  out  1  one-cycle write strobe.
- `out_wr_fifo_data`  out  32  word written when en high.
- `out_overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `out_frame_err`  out  1  sticky: glitch, stuck-high, or partial word discarded.

## Operation
- Word format: bit31 valid, bit30 stream_reset, bits29:24 zero, 23:16 G, 15:8 R, 7:0 B.
  - Data word = {2'b10, 6'b0, G, R, B}.
  - Reset word = 32'hC000_0000.
- Synchronizer: s1<=sig_in, s2<=s1, s3<=s2.
  - rise = s2&~s3; fall = ~s2&s3.
  - All counting uses s2.
- Counter `cnt` saturates at COUNTER_MAX.
- Bit counter `bcnt` runs 0..23; 24-bit shift register `shreg` shifts MSB first (the first bit received lands in bit 23).
- States:
  - S_SYNC (after reset or error): s2 high clears cnt; s2 low increments cnt. When STR_RST consecutive lows are seen, go to S_IDLE. No word is emitted.
  - S_IDLE: line low, nothing pending. A rise sets cnt=1 and goes to S_HIGH. No reset word is emitted from S_IDLE.
  - S_HIGH: cnt increments while s2 high.
    - If cnt reaches STR_RST: set frame_err, clear bcnt, go to S_SYNC.
    - On fall with cnt<GLITCH_MIN: set frame_err, clear bcnt, go to S_SYNC.
    - On a valid fall: bit = (cnt>=BIT_THRESH), shreg <= {shreg[22:0], bit}, then cnt=1 and go to S_LOW.
    - If that was bit 24: emit the data word and set bcnt=0; otherwise bcnt++.
  - S_LOW: cnt increments while s2 low.
    - A rise sets cnt=1 and goes to S_HIGH.
    - On the STR_RST-th consecutive low sample: emit the reset word, and set frame_err if bcnt≠0. Then clear bcnt and go to S_IDLE.
- Emit:
  - If in_wr_fifo_full=0, register the data and pulse en for exactly 1 cycle.
  - If in_wr_fifo_full=1, en stays 0, the word is dropped, and out_overflow is set.
  - Full is sampled in the emitting cycle.
- Reset values: out_wr_fifo_en=0, out_wr_fifo_data=0, out_overflow=0, out_frame_err=0. Also s1/s2/s3=0, cnt=0, bcnt=0, shreg=0, state=S_SYNC.
- rst mid-word discards the partial word; sticky flags clear only on rst.

## Timing
- The sig_in→s2 latency is 2 clocks, so measured high/low widths equal the sampled sig_in widths exactly.
- Data word latency: en is high in the cycle after the 3rd posedge at which sig_in is sampled low following bit 24's high.
- Reset word latency: en is high in the cycle following the posedge that registers the STR_RST-th consecutive low s2 sample.
- Emissions are at least (GLITCH_MIN+1) clocks apart, so en never stays high two consecutive cycles.
- A rise arriving on the sample that would have been the STR_RST-th low is a high sample, so no reset is emitted and the pulse is decoded.
- Boundaries:
  - High width BIT_THRESH-1 decodes as 0; BIT_THRESH decodes as 1.
  - High width GLITCH_MIN-1 is an error; GLITCH_MIN is valid.
  - Low width STR_RST-1 is inter-bit; STR_RST is a reset.

## Test plan
Bench parameters: BIT_THRESH=6, GLITCH_MIN=2, STR_RST=40, COUNTER_MAX=50; 0-pulse = 3H/9L, 1-pulse = 8H/4L.

1. Reset, 40 low, 24 bits of G=0x12 R=0x34 B=0x56, then 45 low → writes 0x8012_3456, then 0xC000_0000; both flags stay 0.
2. Pulses high 5 and 6 clocks, within 24 bits of otherwise-zero → the two target bits decode 0 then 1 in the word.
3. A 1-clock high glitch mid-word → no word, frame_err=1. After 40 low, a full frame is decoded correctly.
4. 10 bits then 40 low → only 0xC000_0000 written, frame_err=1. The next 24 bits yield the correct word with no stale bits.
5. in_wr_fifo_full=1 at bit-24 completion → en stays 0, overflow=1. The next word is written once full=0.
6. rst asserted after 12 bits, then 40 low and a full frame → all outputs are 0 during rst, the correct word is written afterwards, and flags are 0.
